// File: rtl/microprocessor_led_pio.sv
// microprocessor_led_pio: Avalon-MM LED output port with atomic set/clear/toggle
// registers, a per-bit blink mask and a programmable blink prescaler.
//
// Register map (word addresses):
//   0 DATA    r/w     LED data
//   1 MASK    r/w     bits set here blink with the prescaler phase
//   2 PERIOD  r/w     half blink period in clock cycles (0 freezes blinking on)
//   3 STATUS  r       bit0 = blink phase
//   4 SET     w       DATA |= wd
//   5 CLEAR   w       DATA &= ~wd
//   6 TOGGLE  w       DATA ^= wd
//   7         -       reserved, reads 0
module microprocessor_led_pio #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned RESET_DATA   = 0,
  parameter int unsigned RESET_PERIOD = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int unsigned ADDR_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PERIOD = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SET    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLEAR  = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOGGLE = ADDR_WIDTH'(6);

  localparam logic [DATA_WIDTH-1:0]   DATA_RST   = DATA_WIDTH'(RESET_DATA);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_RST = PERIOD_WIDTH'(RESET_PERIOD);

  // Architectural state
  logic [DATA_WIDTH-1:0]   data_q,   data_d;
  logic [DATA_WIDTH-1:0]   mask_q,   mask_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q,    cnt_d;
  logic                    phase_q,  phase_d;
  logic [DATA_WIDTH-1:0]   out_d;

  // Bus decode helpers
  logic                    wr_en;
  logic                    period_wr;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [PERIOD_WIDTH-1:0] wd_period;
  logic [PERIOD_WIDTH-1:0] period_last;

  // Upper writedata bits are intentionally ignored by the register file.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en       = chipselect & ~write_n;
  assign wd_data     = writedata[DATA_WIDTH-1:0];
  assign wd_period   = writedata[PERIOD_WIDTH-1:0];
  assign period_last = period_q - PERIOD_WIDTH'(1);

  // Register-file next state; set/clear/toggle act on the pre-edge DATA value.
  always_comb begin
    data_d    = data_q;
    mask_d    = mask_q;
    period_d  = period_q;
    period_wr = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d = wd_data;
        ADDR_MASK:   mask_d = wd_data;
        ADDR_PERIOD: begin
          period_d  = wd_period;
          period_wr = 1'b1;
        end
        ADDR_SET:    data_d = data_q | wd_data;
        ADDR_CLEAR:  data_d = data_q & ~wd_data;
        ADDR_TOGGLE: data_d = data_q ^ wd_data;
        default:     ;
      endcase
    end
  end

  // Blink prescaler; a PERIOD write or a zero period restarts/freezes with phase on.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr || (period_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_last) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_WIDTH'(1);
    end
  end

  // LED drive computed from the post-edge state so the port tracks writes in one edge.
  always_comb begin
    out_d = (data_d & ~mask_d) | (data_d & mask_d & {DATA_WIDTH{phase_d}});
  end

  // State and output registers with synchronous reset; reset discards any bus write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= DATA_RST;
      mask_q   <= '0;
      period_q <= PERIOD_RST;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_port <= DATA_RST;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_port <= out_d;
    end
  end

  // Zero-latency read mux; independent of chipselect, unused addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_MASK:   readdata = 32'(mask_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_STATUS: readdata = {31'd0, phase_q};
      default:     readdata = '0;
    endcase
  end

endmodule
